rxdatreg: RTL and testbench

- Receive-side data register for the USRT peripheral bus; counterpart to the Tx data register.
- Accepts completed bytes from the Rx shift register and buffers them in a small FIFO.
- Serves them to the bus master with the same Enable/Pready read handshake the Tx side uses for writes.
- Flags overrun when the shift register delivers a byte while the buffer is full.

---
 rtl/rxdatreg_if.sv | 68 ++++++
 rtl/rxdatreg.sv | 167 ++++++++++++++++
 tb/tb_rxdatreg.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rxdatreg_if.sv
// -----------------------------------------------------------------------------
// rxdatreg_if
// Bus bundle between the USRT Rx data register and its neighbours (Rx shift
// register on the write side, peripheral bus master on the read side).
//
// Parameters:
//   ADDR_W     FIFO pointer width; o_Count is ADDR_W+1 bits wide
//
// Signals:
//   i_Valid    one-cycle pulse: i_Data holds a completed byte
//   i_Data     received byte
//   i_Enable   bus read request, held until o_Pready
//   i_Clear    clears the sticky overrun flag
//   o_Pready   one-cycle pulse: o_Data holds the popped byte
//   o_Data     last byte read, stable until the next pop
//   o_Empty    FIFO holds no bytes
//   o_Full     FIFO holds DEPTH bytes
//   o_Count    number of bytes held
//   o_Overrun  sticky: at least one byte was dropped
//   i_PErr / o_PErr  parity error bit travelling with each byte
//                    (only when RXDATREG_PERR_EN is defined)
//
// Modports:
//   master     bus master / shift-register side
//   slave      the rxdatreg block
// -----------------------------------------------------------------------------
interface rxdatreg_if #(
   parameter int unsigned ADDR_W = 2
) ();

   logic              i_Valid;
   logic [7:0]        i_Data;
   logic              i_Enable;
   logic              i_Clear;
   logic              o_Pready;
   logic [7:0]        o_Data;
   logic              o_Empty;
   logic              o_Full;
   logic [ADDR_W:0]   o_Count;
   logic              o_Overrun;
`ifdef RXDATREG_PERR_EN
   logic              i_PErr;
   logic              o_PErr;
`endif

`ifdef RXDATREG_PERR_EN
   modport master (
      output i_Valid, i_Data, i_Enable, i_Clear, i_PErr,
      input  o_Pready, o_Data, o_Empty, o_Full, o_Count, o_Overrun, o_PErr
   );

   modport slave (
      input  i_Valid, i_Data, i_Enable, i_Clear, i_PErr,
      output o_Pready, o_Data, o_Empty, o_Full, o_Count, o_Overrun, o_PErr
   );
`else
   modport master (
      output i_Valid, i_Data, i_Enable, i_Clear,
      input  o_Pready, o_Data, o_Empty, o_Full, o_Count, o_Overrun
   );

   modport slave (
      input  i_Valid, i_Data, i_Enable, i_Clear,
      output o_Pready, o_Data, o_Empty, o_Full, o_Count, o_Overrun
   );
`endif

endinterface : rxdatreg_if

// File: rtl/rxdatreg.sv
// -----------------------------------------------------------------------------
// rxdatreg
// Receive-side data register of the USRT peripheral. Completed bytes from the
// Rx shift register are buffered in a DEPTH-entry FIFO and handed to the bus
// master with the Enable/Pready read handshake. A byte arriving while the FIFO
// is full (and nothing is popped that cycle) is dropped and sets a sticky
// overrun flag.
//
// Parameters:
//   DEPTH    number of byte entries, power of two, >= 2
//   ADDR_W   pointer width, must equal log2(DEPTH)
//
// Ports:
//   i_Pclk    peripheral clock, rising edge
//   i_Resetn  asynchronous active-low reset
//   bus       rxdatreg_if.slave bundle (Valid/Data in, Enable/Pready read
//             handshake, Empty/Full/Count/Overrun status)
//
// Configuration macro:
//   RXDATREG_PERR_EN  when defined, each entry carries a parity-error bit
//                     (bus.i_PErr in, bus.o_PErr out alongside o_Data).
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module rxdatreg #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic        i_Pclk,
   input  logic        i_Resetn,
   rxdatreg_if.slave   bus
);

`ifdef RXDATREG_PERR_EN
   localparam int unsigned ENTRY_W = 9;
`else
   localparam int unsigned ENTRY_W = 8;
`endif
   localparam int unsigned CNT_W   = ADDR_W + 1;

   // Storage (no reset: contents are meaningless while count is zero)
   logic [ENTRY_W-1:0] mem [DEPTH];

   // Registered state and its next-state values
   logic [ADDR_W-1:0]  wptr_q,    wptr_d;
   logic [ADDR_W-1:0]  rptr_q,    rptr_d;
   logic [CNT_W-1:0]   count_q,   count_d;
   logic               empty_q,   empty_d;
   logic               full_q,    full_d;
   logic [7:0]         data_q,    data_d;
   logic               pready_q,  pready_d;
   logic               overrun_q, overrun_d;
`ifdef RXDATREG_PERR_EN
   logic               perr_q,    perr_d;
`endif

   // Per-cycle decisions
   logic               pop_c;
   logic               push_c;
   logic               drop_c;
   logic [ENTRY_W-1:0] wr_entry_c;
   logic [ENTRY_W-1:0] rd_entry_c;

   // Entry packing
`ifdef RXDATREG_PERR_EN
   assign wr_entry_c = {bus.i_PErr, bus.i_Data};
`else
   assign wr_entry_c = bus.i_Data;
`endif
   assign rd_entry_c = mem[rptr_q];

   // Flow decisions use registered empty/full only. A pop frees a slot in
   // the same edge, so a full FIFO still accepts the incoming byte when the
   // master reads in that cycle; an empty FIFO cannot forward a byte that is
   // only just being written.
   assign pop_c  = bus.i_Enable & ~empty_q;
   assign push_c = bus.i_Valid  & (~full_q | pop_c);
   assign drop_c = bus.i_Valid  &   full_q  & ~pop_c;

   // Next-state logic
   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      empty_d   = empty_q;
      full_d    = full_q;
      data_d    = data_q;
      pready_d  = 1'b0;
      overrun_d = overrun_q;
`ifdef RXDATREG_PERR_EN
      perr_d    = perr_q;
`endif

      // Pointers wrap naturally: DEPTH is 2**ADDR_W
      if (push_c) begin
         wptr_d = wptr_q + ADDR_W'(1);
      end

      if (pop_c) begin
         rptr_d   = rptr_q + ADDR_W'(1);
         data_d   = rd_entry_c[7:0];
         pready_d = 1'b1;
`ifdef RXDATREG_PERR_EN
         perr_d   = rd_entry_c[8];
`endif
      end

      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_W'(DEPTH));

      // Sticky overrun: a new drop takes priority over a clear
      if (drop_c) begin
         overrun_d = 1'b1;
      end else if (bus.i_Clear) begin
         overrun_d = 1'b0;
      end
   end

   // State register
   always_ff @(posedge i_Pclk or negedge i_Resetn) begin
      if (!i_Resetn) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         data_q    <= '0;
         pready_q  <= 1'b0;
         overrun_q <= 1'b0;
`ifdef RXDATREG_PERR_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         data_q    <= data_d;
         pready_q  <= pready_d;
         overrun_q <= overrun_d;
`ifdef RXDATREG_PERR_EN
         perr_q    <= perr_d;
`endif
      end
   end

   // FIFO write port
   always_ff @(posedge i_Pclk) begin
      if (push_c) begin
         mem[wptr_q] <= wr_entry_c;
      end
   end

   // Output drive
   assign bus.o_Pready  = pready_q;
   assign bus.o_Data    = data_q;
   assign bus.o_Empty   = empty_q;
   assign bus.o_Full    = full_q;
   assign bus.o_Count   = count_q;
   assign bus.o_Overrun = overrun_q;
`ifdef RXDATREG_PERR_EN
   assign bus.o_PErr    = perr_q;
`endif

endmodule : rxdatreg

// File: tb/tb_rxdatreg.sv
// -----------------------------------------------------------------------------
// tb_rxdatreg
// Self-checking bench for rxdatreg. A queue-based reference model tracks the
// bytes held, the last popped byte, the read pulse and the overrun flag; every
// cycle all outputs are compared against it. Directed scenarios cover the
// read handshake, stalled reads, overrun, full+pop, pointer wrap and async
// reset; randomized phases then stress arbitrary push/pop/clear mixes.
// -----------------------------------------------------------------------------
module tb_rxdatreg;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 2;

   logic i_Pclk   = 1'b0;
   logic i_Resetn = 1'b1;

   always #5 i_Pclk = ~i_Pclk;

   rxdatreg_if #(.ADDR_W(ADDR_W)) bus ();

   rxdatreg #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dut (
      .i_Pclk   (i_Pclk),
      .i_Resetn (i_Resetn),
      .bus      (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [8:0] mdl_q [$];
   logic [7:0] mdl_data;
   logic       mdl_perr;
   logic       mdl_pready;
   logic       mdl_ovr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pready"},  32'(bus.o_Pready),  32'(mdl_pready));
      check({tag, ".data"},    32'(bus.o_Data),    32'(mdl_data));
      check({tag, ".count"},   32'(bus.o_Count),   32'(mdl_q.size()));
      check({tag, ".empty"},   32'(bus.o_Empty),   32'(mdl_q.size() == 0));
      check({tag, ".full"},    32'(bus.o_Full),    32'(mdl_q.size() == DEPTH));
      check({tag, ".overrun"}, 32'(bus.o_Overrun), 32'(mdl_ovr));
`ifdef RXDATREG_PERR_EN
      check({tag, ".perr"},    32'(bus.o_PErr),    32'(mdl_perr));
`endif
   endtask

   // One clock cycle: drive inputs, take the edge, advance the model, compare.
   task automatic step(input string tag, input logic v, input logic [7:0] d,
                       input logic en, input logic clr, input logic pe);
      int         sz;
      logic       pop;
      logic       dropped;
      logic [8:0] e;
      bus.i_Valid  = v;
      bus.i_Data   = d;
      bus.i_Enable = en;
      bus.i_Clear  = clr;
`ifdef RXDATREG_PERR_EN
      bus.i_PErr   = pe;
`endif
      @(posedge i_Pclk);
      sz         = mdl_q.size();
      pop        = en && (sz > 0);
      dropped    = v && (sz == DEPTH) && !pop;
      mdl_pready = pop;
      if (pop) begin
         e        = mdl_q.pop_front();
         mdl_data = e[7:0];
         mdl_perr = e[8];
      end
      if (v && !dropped) mdl_q.push_back({pe, d});
      if (dropped)   mdl_ovr = 1'b1;
      else if (clr)  mdl_ovr = 1'b0;
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      bus.i_Valid  = 1'b0;
      bus.i_Data   = 8'h00;
      bus.i_Enable = 1'b0;
      bus.i_Clear  = 1'b0;
`ifdef RXDATREG_PERR_EN
      bus.i_PErr   = 1'b0;
`endif
   endtask

   // Asynchronous reset asserted between edges; outputs checked before any edge.
   task automatic do_reset(input string tag);
      #2;
      i_Resetn = 1'b0;
      mdl_q.delete();
      mdl_data   = 8'h00;
      mdl_perr   = 1'b0;
      mdl_pready = 1'b0;
      mdl_ovr    = 1'b0;
      #1;
      check_all(tag);
      idle_inputs();
      @(posedge i_Pclk);
      @(posedge i_Pclk);
      #1;
      i_Resetn = 1'b1;
   endtask

   initial begin
      idle_inputs();
      mdl_data   = 8'h00;
      mdl_perr   = 1'b0;
      mdl_pready = 1'b0;
      mdl_ovr    = 1'b0;
      @(posedge i_Pclk);
      #1;
      do_reset("rst0");

      // Single byte round trip
      step("t1.push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      step("t1.read", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t1.a5", 32'(bus.o_Data), 32'h0000_00A5);
      step("t1.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Read stalled on empty FIFO, then push: Pready two edges after push
      for (int i = 0; i < 5; i++) step("t2.stall", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step("t2.push", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      check("t2.nopready", 32'(bus.o_Pready), 32'h0);
      step("t2.pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t2.3c", 32'(bus.o_Data), 32'h0000_003C);
      step("t2.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Fill, overrun, drain, clear
      for (int i = 1; i <= 4; i++) step("t3.fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      check("t3.full", 32'(bus.o_Full), 32'h1);
      step("t3.ovr", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      check("t3.ovrset", 32'(bus.o_Overrun), 32'h1);
      for (int i = 1; i <= 4; i++) begin
         step("t3.drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         check("t3.byte", 32'(bus.o_Data), 32'(i));
      end
      step("t3.clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("t3.ovrclr", 32'(bus.o_Overrun), 32'h0);

      // Full with simultaneous push and pop, pointer wrap
      for (int i = 0; i < 4; i++) step("t4.fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      step("t4.both", 1'b1, 8'h14, 1'b1, 1'b0, 1'b0);
      check("t4.first", 32'(bus.o_Data), 32'h10);
      check("t4.noovr", 32'(bus.o_Overrun), 32'h0);
      for (int i = 1; i <= 4; i++) begin
         step("t4.drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         check("t4.byte", 32'(bus.o_Data), 32'(8'h10 + i));
      end

      // Overrun and clear in the same cycle: set wins
      for (int i = 0; i < 4; i++) step("t5.fill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      step("t5.setclr", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      check("t5.setwins", 32'(bus.o_Overrun), 32'h1);

      // Reset with 3 bytes held and a nonzero o_Data
      step("t5.pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t5.held3", 32'(bus.o_Count), 32'h3);
      do_reset("t5.rst");

`ifdef RXDATREG_PERR_EN
      // Parity error bit travels with its byte
      step("t6.push55", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      step("t6.pushaa", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      step("t6.rd55",   1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t6.perr1", 32'(bus.o_PErr), 32'h1);
      step("t6.rdaa",   1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t6.perr0", 32'(bus.o_PErr), 32'h0);
`endif

      // Randomized phases: push-heavy, balanced, pop-heavy
      for (int ph = 0; ph < 3; ph++) begin
         for (int n = 0; n < 200; n++) begin
            logic v, en, clr, pe;
            v   = ($urandom_range(99) < (ph == 0 ? 75 : (ph == 1 ? 50 : 25)));
            en  = ($urandom_range(99) < (ph == 0 ? 25 : (ph == 1 ? 50 : 75)));
            clr = ($urandom_range(15) == 0);
            pe  = 1'($urandom);
            step("rnd", v, 8'($urandom), en, clr, pe);
         end
         if (ph == 1) do_reset("rnd.rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rxdatreg
